// File: rtl/t03_mmio_periph_pkg.sv
// t03_mmio_pkg: register offsets and window size shared by the MMIO peripheral.
// No ports. Offsets are byte offsets inside the 64-byte register window.
package t03_mmio_pkg;
  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h04;
  localparam logic [5:0] OFF_RISE     = 6'h08;
  localparam logic [5:0] OFF_FALL     = 6'h0C;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h10;
  localparam logic [5:0] OFF_PWM_BASE = 6'h20;
  localparam logic [5:0] PWM_STRIDE   = 6'h08;
  localparam logic [31:0] WINDOW_BYTES = 32'h40;
endpackage

// File: rtl/t03_mmio_periph_if.sv
// t03_mmio_periph_if: CPU data-memory bus seen by the MMIO peripheral.
// Ports (signals): write_mem, read_mem, data_address, data_to_write, data_from_mem
// driven by the master; data_read returned by the slave.
interface t03_mmio_periph_if;
  logic        write_mem;
  logic        read_mem;
  logic [31:0] data_address;
  logic [31:0] data_to_write;
  logic [31:0] data_from_mem;
  logic [31:0] data_read;
  modport master (output write_mem, read_mem, data_address, data_to_write, data_from_mem, input data_read);
  modport slave  (input write_mem, read_mem, data_address, data_to_write, data_from_mem, output data_read);
endinterface

// File: rtl/t03_mmio_periph_pwm_channel.sv
// t03_pwm_channel: one PWM generator with shadowed period/duty.
// Ports: clk, rst (async, active-high); per_we_i/duty_we_i + wdata_i load the shadows;
// per_o/duty_o return the shadows for readback; pwm_o is the registered waveform.
module t03_pwm_channel #(
  parameter int PWM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_we_i,
  input  logic             duty_we_i,
  input  logic [PWM_W-1:0] wdata_i,
  output logic [PWM_W-1:0] per_o,
  output logic [PWM_W-1:0] duty_o,
  output logic             pwm_o
);
  logic [PWM_W-1:0] per_s_q, per_s_d, duty_s_q, duty_s_d;
  logic [PWM_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d, load;
  // cnt is held at 0 while idle, so this also covers per_a == 0
  assign load = cnt_q == per_a_q;
  always_comb begin
    per_s_d  = per_we_i ? wdata_i : per_s_q;
    duty_s_d = duty_we_i ? wdata_i : duty_s_q;
    per_a_d  = load ? per_s_q : per_a_q;
    duty_a_d = load ? duty_s_q : duty_a_q;
    cnt_d    = load ? '0 : cnt_q + 1'b1;
    pwm_d    = per_a_q != '0 && cnt_q < duty_a_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_s_q  <= '0;
      duty_s_q <= '0;
      per_a_q  <= '0;
      duty_a_q <= '0;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      per_s_q  <= per_s_d;
      duty_s_q <= duty_s_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end
  assign per_o  = per_s_q;
  assign duty_o = duty_s_q;
  assign pwm_o  = pwm_q;
endmodule

// File: rtl/t03_mmio_periph.sv
// t03_mmio_periph: MMIO GPIO / edge-interrupt / PWM block on the data-memory path.
// Ports: clk, rst (async, active-high); bus (slave modport of t03_mmio_periph_if);
// gpio_in (async pads), gpio_out, pwm_out[NUM_PWM], irq (registered level).
// Option T03_MMIO_FALL_IRQ_EN: adds FALL_STAT and fall enables at IRQ_EN[GPIO_W+15:16]
// (requires GPIO_W <= 16).
module t03_mmio_periph import t03_mmio_pkg::*; #(
  parameter int          NUM_PWM   = 2,
  parameter int          GPIO_W    = 32,
  parameter int          PWM_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h31FF_FF00
) (
  input  logic               clk,
  input  logic               rst,
  t03_mmio_periph_if.slave   bus,
  input  logic [GPIO_W-1:0]  gpio_in,
  output logic [GPIO_W-1:0]  gpio_out,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);
  // only four channels fit in the window; the rest are unreachable
  localparam int NVIS = NUM_PWM < 4 ? NUM_PWM : 4;
  logic              hit, wr, rd;
  logic [5:0]        off;
  logic [GPIO_W-1:0] wd_g;
  logic [GPIO_W-1:0] gpio_q, gpio_d, s1_q, s2_q, prev_q;
  logic [GPIO_W-1:0] rise_q, rise_d, en_r_q, en_r_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata;
  logic [PWM_W-1:0]  per_rd [NUM_PWM];
  logic [PWM_W-1:0]  duty_rd [NUM_PWM];
`ifdef T03_MMIO_FALL_IRQ_EN
  logic [GPIO_W-1:0] fall_q, fall_d, en_f_q, en_f_d;
`endif
  assign hit  = bus.data_address >= BASE_ADDR && bus.data_address < BASE_ADDR + WINDOW_BYTES;
  assign off  = {bus.data_address[5:2], 2'b00};
  assign wr   = bus.write_mem & hit;
  assign rd   = bus.read_mem & ~bus.write_mem & hit;
  assign wd_g = bus.data_to_write[GPIO_W-1:0];
  always_comb begin
    gpio_d = (wr && off == OFF_GPIO_OUT) ? wd_g : gpio_q;
    // a fresh edge in the same cycle as its W1C keeps the bit set
    rise_d = (rise_q & ~((wr && off == OFF_RISE) ? wd_g : '0)) | (s2_q & ~prev_q);
    en_r_d = (wr && off == OFF_IRQ_EN) ? wd_g : en_r_q;
`ifdef T03_MMIO_FALL_IRQ_EN
    fall_d = (fall_q & ~((wr && off == OFF_FALL) ? wd_g : '0)) | (~s2_q & prev_q);
    en_f_d = (wr && off == OFF_IRQ_EN) ? bus.data_to_write[GPIO_W+15:16] : en_f_q;
    irq_d  = (|(rise_q & en_r_q)) | (|(fall_q & en_f_q));
`else
    irq_d  = |(rise_q & en_r_q);
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      rise_q <= '0;
      en_r_q <= '0;
      irq_q  <= 1'b0;
`ifdef T03_MMIO_FALL_IRQ_EN
      fall_q <= '0;
      en_f_q <= '0;
`endif
    end else begin
      gpio_q <= gpio_d;
      s1_q   <= gpio_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rise_q <= rise_d;
      en_r_q <= en_r_d;
      irq_q  <= irq_d;
`ifdef T03_MMIO_FALL_IRQ_EN
      fall_q <= fall_d;
      en_f_q <= en_f_d;
`endif
    end
  end
  for (genvar g = 0; g < NUM_PWM; g++) begin : g_pwm
    t03_pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .per_we_i  (wr && g < NVIS && off == 6'(OFF_PWM_BASE + PWM_STRIDE * g)),
      .duty_we_i (wr && g < NVIS && off == 6'(OFF_PWM_BASE + PWM_STRIDE * g + 4)),
      .wdata_i   (bus.data_to_write[PWM_W-1:0]),
      .per_o     (per_rd[g]),
      .duty_o    (duty_rd[g]),
      .pwm_o     (pwm_out[g])
    );
  end
  always_comb begin
    rdata = '0;
    if (off == OFF_GPIO_OUT) rdata = 32'(gpio_q);
    if (off == OFF_GPIO_IN)  rdata = 32'(s2_q);
    if (off == OFF_RISE)     rdata = 32'(rise_q);
`ifdef T03_MMIO_FALL_IRQ_EN
    if (off == OFF_FALL)     rdata = 32'(fall_q);
    if (off == OFF_IRQ_EN)   rdata = 32'(en_r_q) | (32'(en_f_q) << 16);
`else
    if (off == OFF_IRQ_EN)   rdata = 32'(en_r_q);
`endif
    for (int i = 0; i < NVIS; i++) begin
      if (off == 6'(OFF_PWM_BASE + PWM_STRIDE * i))     rdata = 32'(per_rd[i]);
      if (off == 6'(OFF_PWM_BASE + PWM_STRIDE * i + 4)) rdata = 32'(duty_rd[i]);
    end
  end
  assign bus.data_read = rd ? rdata : bus.data_from_mem;
  assign gpio_out      = gpio_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_t03_mmio_periph.sv
// tb_t03_mmio_periph: directed self-checking bench for t03_mmio_periph.
module tb_t03_mmio_periph;
  localparam logic [31:0] B = 32'h31FF_FF00;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [1:0]  pwm_out;
  logic        irq;
  int          total = 0;
  int          bad = 0;
  t03_mmio_periph_if bus();
  t03_mmio_periph dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .pwm_out  (pwm_out),
    .irq      (irq)
  );
  always #5 clk = ~clk;
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.write_mem = 1'b1;
    bus.data_address = a;
    bus.data_to_write = d;
    @(negedge clk);
    bus.write_mem = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.read_mem = 1'b1;
    bus.data_address = a;
    #1 v = bus.data_read;
    bus.read_mem = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(negedge clk);
    total++; if (gpio_out !== 32'h0 || pwm_out !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL reset_outs got=%h/%b/%b exp=0/00/0", gpio_out, pwm_out, irq); end
    bus.data_from_mem = 32'h1234_5678;
    rd(B + 32'h20, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_period got=%h exp=0", v); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_passthrough();
    logic [31:0] v;
    bus.data_from_mem = 32'hDEAD_BEEF;
    rd(32'h1000_0000, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL passthru_rd got=%h exp=deadbeef", v); end
    rd(B + 32'h40, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL above_window got=%h exp=deadbeef", v); end
    rd(B - 32'h4, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL below_window got=%h exp=deadbeef", v); end
    @(negedge clk);
    wr(32'h1000_0000, 32'hFFFF_FFFF);
    wr(B + 32'h40, 32'hFFFF_FFFF);
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL passthru_wr_gpio got=%h exp=0", gpio_out); end
    rd(B + 32'h10, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL passthru_wr_irqen got=%h exp=0", v); end
    @(negedge clk);
    bus.read_mem = 1'b1;
    bus.write_mem = 1'b1;
    bus.data_address = B + 32'h04;
    bus.data_to_write = 32'h0;
    #1;
    total++; if (bus.data_read !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_wr_both got=%h exp=deadbeef", bus.data_read); end
    @(negedge clk);
    bus.read_mem = 1'b0;
    bus.write_mem = 1'b0;
  endtask
  task automatic test_gpio();
    logic [31:0] v;
    wr(B, 32'hA5A5_0F0F);
    total++; if (gpio_out !== 32'hA5A5_0F0F) begin bad++; $display("FAIL gpio_out got=%h exp=a5a50f0f", gpio_out); end
    rd(B + 32'h3, v);
    total++; if (v !== 32'hA5A5_0F0F) begin bad++; $display("FAIL gpio_out_rd got=%h exp=a5a50f0f", v); end
    @(negedge clk);
    gpio_in = 32'h3;
    @(negedge clk);
    rd(B + 32'h4, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL gpio_in_1cyc got=%h exp=0", v); end
    @(negedge clk);
    rd(B + 32'h4, v);
    total++; if (v !== 32'h3) begin bad++; $display("FAIL gpio_in_2cyc got=%h exp=3", v); end
    @(negedge clk);
  endtask
  task automatic test_edge_irq();
    logic [31:0] v;
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    wr(B + 32'h08, 32'hFFFF_FFFF);
    wr(B + 32'h10, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    gpio_in = 32'h1;
    repeat (2) @(negedge clk);
    rd(B + 32'h08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rise_2cyc got=%h exp=0", v); end
    @(negedge clk);
    rd(B + 32'h08, v);
    total++; if (v !== 32'h1 || irq !== 1'b0) begin bad++; $display("FAIL rise_3cyc got=%h/%b exp=1/0", v, irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_4cyc got=%b exp=1", irq); end
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    rd(B + 32'h0C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL fall_unimpl got=%h exp=0", v); end
    @(negedge clk);
    gpio_in = 32'h1;
    repeat (2) @(negedge clk);
    wr(B + 32'h08, 32'h1);
    rd(B + 32'h08, v);
    total++; if (v !== 32'h1 || irq !== 1'b1) begin bad++; $display("FAIL set_wins got=%h/%b exp=1/1", v, irq); end
    @(negedge clk);
    wr(B + 32'h08, 32'h1);
    rd(B + 32'h08, v);
    total++; if (v !== 32'h0 || irq !== 1'b1) begin bad++; $display("FAIL w1c_clear got=%h/%b exp=0/1", v, irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%b exp=0", irq); end
  endtask
  task automatic test_pwm();
    logic [9:0] p [3];
    logic       prv;
    int         n;
    wr(B + 32'h24, 32'd3);
    wr(B + 32'h20, 32'd9);
    prv = pwm_out[0];
    @(negedge clk);
    n = 1;
    while (!(!prv && pwm_out[0]) && n < 40) begin
      prv = pwm_out[0];
      @(negedge clk);
      n++;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL pwm_rise_timeout got=%0d exp<40", n); end
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      p[k / 10][k % 10] = pwm_out[0];
      if (k == 12) begin
        bus.write_mem = 1'b1;
        bus.data_address = B + 32'h24;
        bus.data_to_write = 32'd7;
      end
      if (k == 13) bus.write_mem = 1'b0;
    end
    total++; if (p[0] !== 10'h007) begin bad++; $display("FAIL pwm_period1 got=%b exp=%b", p[0], 10'h007); end
    total++; if (p[1] !== 10'h007) begin bad++; $display("FAIL pwm_period2 got=%b exp=%b", p[1], 10'h007); end
    total++; if (p[2] !== 10'h07F) begin bad++; $display("FAIL pwm_period3 got=%b exp=%b", p[2], 10'h07F); end
  endtask
  task automatic test_boundaries();
    logic [11:0] s;
    logic [31:0] v;
    @(negedge clk);
    wr(B + 32'h24, 32'd12);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 12; k++) begin @(negedge clk); s[k] = pwm_out[0]; end
    total++; if (s !== 12'hFFF) begin bad++; $display("FAIL duty_gt_per got=%b exp=all1", s); end
    wr(B + 32'h24, 32'd0);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 12; k++) begin @(negedge clk); s[k] = pwm_out[0]; end
    total++; if (s !== 12'h000) begin bad++; $display("FAIL duty_zero got=%b exp=all0", s); end
    wr(B + 32'h24, 32'd5);
    wr(B + 32'h20, 32'd0);
    repeat (25) @(negedge clk);
    for (int k = 0; k < 12; k++) begin @(negedge clk); s[k] = pwm_out[0]; end
    total++; if (s !== 12'h000) begin bad++; $display("FAIL period_zero got=%b exp=all0", s); end
    total++; if (dut.g_pwm[0].u_ch.cnt_q !== 16'd0) begin bad++; $display("FAIL period_zero_cnt got=%0d exp=0", dut.g_pwm[0].u_ch.cnt_q); end
    bus.data_from_mem = 32'hDEAD_BEEF;
    rd(B + 32'h38, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_ch3 got=%h exp=0", v); end
    rd(B + 32'h14, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_14 got=%h exp=0", v); end
    rd(B + 32'h24, v);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL duty_readback got=%h exp=5", v); end
    @(negedge clk);
  endtask
  task automatic test_async_reset();
    logic [31:0] v;
    logic [11:0] s;
    int          n;
    wr(B, 32'hFF);
    wr(B + 32'h20, 32'd9);
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    gpio_in = 32'h1;
    repeat (5) @(negedge clk);
    total++; if (irq !== 1'b1 || gpio_out !== 32'hFF) begin bad++; $display("FAIL pre_reset got=%b/%h exp=1/ff", irq, gpio_out); end
    n = 0;
    while (pwm_out[0] !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    total++; if (n >= 30) begin bad++; $display("FAIL pre_reset_pwm_timeout got=%0d exp<30", n); end
    #2 rst = 1'b1;
    #1;
    total++; if (gpio_out !== 32'h0 || pwm_out !== 2'b00 || irq !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b/%b exp=0/00/0", gpio_out, pwm_out, irq); end
    @(negedge clk);
    rst = 1'b0;
    rd(B + 32'h20, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_period got=%h exp=0", v); end
    rd(B + 32'h10, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_irqen got=%h exp=0", v); end
    for (int k = 0; k < 12; k++) begin @(negedge clk); s[k] = pwm_out[0]; end
    total++; if (s !== 12'h000) begin bad++; $display("FAIL post_reset_pwm got=%b exp=all0", s); end
  endtask
  initial begin
    bus.write_mem = 1'b0;
    bus.read_mem = 1'b0;
    bus.data_address = '0;
    bus.data_to_write = '0;
    bus.data_from_mem = '0;
    test_reset();
    test_passthrough();
    test_gpio();
    test_edge_irq();
    test_pwm();
    test_boundaries();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
